// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write path.
//   RF_AW / RF_DW : address and data width of the 32x32 register file
//   RF_NREG       : number of architectural registers (2^RF_AW)
//   rf_wr_t       : one write transaction {we, addr, data}; used for the
//                   arbiter output register and for each request bundle
//                   (on a request bundle, 'we' carries the valid bit)
//   req_idx_e     : names of the two writeback sources
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int RF_NREG = 1 << RF_AW;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_idx_e;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter_if
// Bundles everything between the writeback sources, the arbiter and the
// register file write port.
//   hold                       : stall, no grant this cycle
//   reqN_valid/addr/data       : writeback requests (N = 0 ALU, 1 load)
//   reqN_ready                 : request N is accepted this cycle
//   wE / rW / busW             : registered register-file write port
//   pend                       : one-hot of rW while wE is high
//   last_gnt                   : index of the most recent grant
// master = writeback/decode side, slave = the arbiter.
// ---------------------------------------------------------------------------
interface rf_wr_arbiter_if
    import rf_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
);

    localparam int NREG = 1 << AW;

    logic            hold;
    logic            req0_valid;
    logic [AW-1:0]   req0_addr;
    logic [DW-1:0]   req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [AW-1:0]   req1_addr;
    logic [DW-1:0]   req1_data;
    logic            req1_ready;
    logic            wE;
    logic [AW-1:0]   rW;
    logic [DW-1:0]   busW;
    logic [NREG-1:0] pend;
    logic            last_gnt;

    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wE, rW, busW, pend, last_gnt
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wE, rW, busW, pend, last_gnt
    );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req[1:0]  : request vector
//   hold      : suppresses every grant
//   ptr       : index of the previous grant
//   gnt[1:0]  : one-hot grant (or zero)
//   ptr_next  : pointer after this cycle; unchanged when nothing is granted
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       hold,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (!hold) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (gnt[1]) begin
            ptr_next = 1'b1;
        end else if (gnt[0]) begin
            ptr_next = 1'b0;
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter
// Write-port arbiter for the single-write-port register file. Picks one of
// the ALU / load writebacks per cycle by round-robin and registers it onto
// the write port for exactly one cycle; the register file commits it on the
// following falling edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rf_wr_arbiter_if.slave (requests, readies, write port,
//                pend one-hot, round-robin pointer)
// Parameters DW / AW must match the interface instance and rf_pkg widths.
// ---------------------------------------------------------------------------
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wr_arbiter_if.slave    bus
);

    localparam int NREG = 1 << AW;

    rf_wr_t        req_bundle [2];
    logic [1:0]    req_vec;
    logic [1:0]    gnt;
    logic          arb_hold;
    logic          ptr_next;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    rf_wr_t        wr_q;
    req_idx_e      last_gnt_q;
    logic [NREG-1:0] pend_d;

    assign req_bundle[0] = '{we: bus.req0_valid, addr: bus.req0_addr, data: bus.req0_data};
    assign req_bundle[1] = '{we: bus.req1_valid, addr: bus.req1_addr, data: bus.req1_data};
    assign req_vec       = {req_bundle[1].we, req_bundle[0].we};

    // Reset is treated like hold so no requester sees an acceptance that
    // the held-in-reset output register would silently throw away.
    assign arb_hold = bus.hold | ~rst_n;

    rr_arb2 u_arb (
        .req      (req_vec),
        .hold     (arb_hold),
        .ptr      (last_gnt_q),
        .gnt      (gnt),
        .ptr_next (ptr_next)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    assign sel_addr = gnt[1] ? req_bundle[1].addr : req_bundle[0].addr;
    assign sel_data = gnt[1] ? req_bundle[1].data : req_bundle[0].data;

    // Output register. A write to r0 still uses the grant slot but leaves
    // wE low. Without a grant only wE falls; rW/busW keep the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            last_gnt_q <= REQ_LOAD;
        end else if (|gnt) begin
            wr_q.we    <= (sel_addr != '0);
            wr_q.addr  <= sel_addr;
            wr_q.data  <= sel_data;
            last_gnt_q <= req_idx_e'(ptr_next);
        end else begin
            wr_q.we    <= 1'b0;
        end
    end

    // Register-in-flight decode for the decode-stage stall logic.
    always_comb begin
        pend_d = '0;
        if (wr_q.we) begin
            pend_d[wr_q.addr] = 1'b1;
        end
    end

    assign bus.wE       = wr_q.we;
    assign bus.rW       = wr_q.addr;
    assign bus.busW     = wr_q.data;
    assign bus.pend     = pend_d;
    assign bus.last_gnt = last_gnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wr_arbiter
// Testbench for rf_wr_arbiter with a falling-edge register-file stand-in.
// ---------------------------------------------------------------------------
module tb_rf_wr_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rf_wr_arbiter_if #(.AW(5), .DW(32)) bus ();

    rf_wr_arbiter #(.DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file: writes on the falling edge, r0 hardwired to zero.
    logic [31:0] rf [32] = '{default: 32'h0};

    always @(negedge clk) begin
        if (bus.wE === 1'b1 && bus.rW != 5'd0) rf[bus.rW] <= bus.busW;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_idle();
        bus.hold       = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
    endtask

    // Leaves the bench at rising edge + 1 with reset released.
    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd5;
        bus.req0_data  = 32'h1;
        #1;
        tests_run++; if (bus.req0_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready0: got %b want 0", bus.req0_ready); end
        @(posedge clk); #1;
        tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wE: got %b want 0", bus.wE); end
        tests_run++; if (bus.rW !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_rW: got %0d want 0", bus.rW); end
        tests_run++; if (bus.busW !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_busW: got %h want 0", bus.busW); end
        tests_run++; if (bus.pend !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pend: got %h want 0", bus.pend); end
        tests_run++; if (bus.last_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_last_gnt: got %b want 1", bus.last_gnt); end
        set_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd5;
        bus.req0_data  = 32'hDEADBEEF;
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_ready0: got %b want 1", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_ready1: got %b want 0", bus.req1_ready); end
        @(posedge clk); #1;
        set_idle();
        tests_run++; if (bus.wE !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_wE: got %b want 1", bus.wE); end
        tests_run++; if (bus.rW !== 5'd5) begin tests_failed++; $display("[TB] FAIL single_rW: got %0d want 5", bus.rW); end
        tests_run++; if (bus.busW !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL single_busW: got %h want deadbeef", bus.busW); end
        tests_run++; if (bus.pend !== 32'h20) begin tests_failed++; $display("[TB] FAIL single_pend: got %h want 20", bus.pend); end
        tests_run++; if (bus.last_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_last_gnt: got %b want 0", bus.last_gnt); end
        @(negedge clk); #1;
        tests_run++; if (rf[5] !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL single_rf5: got %h want deadbeef", rf[5]); end
        @(posedge clk); #1;
        tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_wE_drop: got %b want 0", bus.wE); end
        tests_run++; if (bus.busW !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL single_busW_hold: got %h want deadbeef", bus.busW); end
    endtask

    task automatic test_contention();
        int order [4] = '{0, 1, 0, 1};
        logic [4:0] rws [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h111;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h222;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++; if (bus.req0_ready !== (order[k] == 0)) begin tests_failed++; $display("[TB] FAIL contention_ready0[%0d]: got %b want %b", k, bus.req0_ready, order[k] == 0); end
            tests_run++; if (bus.req1_ready !== (order[k] == 1)) begin tests_failed++; $display("[TB] FAIL contention_ready1[%0d]: got %b want %b", k, bus.req1_ready, order[k] == 1); end
            @(posedge clk); #1;
            tests_run++; if (bus.wE !== 1'b1) begin tests_failed++; $display("[TB] FAIL contention_wE[%0d]: got %b want 1", k, bus.wE); end
            tests_run++; if (bus.rW !== rws[k]) begin tests_failed++; $display("[TB] FAIL contention_rW[%0d]: got %0d want %0d", k, bus.rW, rws[k]); end
        end
        set_idle();
    endtask

    task automatic test_r0();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h1234;
        #1;
        tests_run++; if (bus.req1_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL r0_ready1: got %b want 1", bus.req1_ready); end
        @(posedge clk); #1;
        set_idle();
        tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL r0_wE: got %b want 0", bus.wE); end
        tests_run++; if (bus.pend !== 32'h0) begin tests_failed++; $display("[TB] FAIL r0_pend: got %h want 0", bus.pend); end
        tests_run++; if (bus.last_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL r0_last_gnt: got %b want 1", bus.last_gnt); end
        tests_run++; if (bus.busW !== 32'h1234) begin tests_failed++; $display("[TB] FAIL r0_busW: got %h want 1234", bus.busW); end
    endtask

    task automatic test_hold();
        bus.hold = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'hCAFE0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (bus.req0_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_ready0[%0d]: got %b want 0", k, bus.req0_ready); end
            tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_ready1[%0d]: got %b want 0", k, bus.req1_ready); end
            @(posedge clk); #1;
            tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_wE[%0d]: got %b want 0", k, bus.wE); end
            tests_run++; if (bus.busW !== 32'h1234) begin tests_failed++; $display("[TB] FAIL hold_busW[%0d]: got %h want 1234", k, bus.busW); end
        end
        bus.hold = 1'b0;
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_release_ready0: got %b want 1", bus.req0_ready); end
        @(posedge clk); #1;
        set_idle();
        tests_run++; if (bus.wE !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_release_wE: got %b want 1", bus.wE); end
        tests_run++; if (bus.rW !== 5'd9) begin tests_failed++; $display("[TB] FAIL hold_release_rW: got %0d want 9", bus.rW); end
        tests_run++; if (bus.busW !== 32'hCAFE0001) begin tests_failed++; $display("[TB] FAIL hold_release_busW: got %h want cafe0001", bus.busW); end
        @(negedge clk); #1;
        tests_run++; if (rf[9] !== 32'hCAFE0001) begin tests_failed++; $display("[TB] FAIL hold_rf9: got %h want cafe0001", rf[9]); end
        @(posedge clk); #1;
    endtask

    task automatic test_same_target();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'hA;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'hB;
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_ready0: got %b want 1", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL same_ready1_first: got %b want 0", bus.req1_ready); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        tests_run++; if (bus.busW !== 32'hA) begin tests_failed++; $display("[TB] FAIL same_busW_first: got %h want a", bus.busW); end
        #1;
        tests_run++; if (bus.req1_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_ready1_second: got %b want 1", bus.req1_ready); end
        @(negedge clk); #1;
        tests_run++; if (rf[7] !== 32'hA) begin tests_failed++; $display("[TB] FAIL same_rf7_first: got %h want a", rf[7]); end
        @(posedge clk); #1;
        set_idle();
        tests_run++; if (bus.busW !== 32'hB) begin tests_failed++; $display("[TB] FAIL same_busW_second: got %h want b", bus.busW); end
        @(negedge clk); #1;
        tests_run++; if (rf[7] !== 32'hB) begin tests_failed++; $display("[TB] FAIL same_rf7_final: got %h want b", rf[7]); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h55;
        @(posedge clk); #1;
        set_idle();
        tests_run++; if (bus.wE !== 1'b1) begin tests_failed++; $display("[TB] FAIL areset_pre_wE: got %b want 1", bus.wE); end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_wE: got %b want 0", bus.wE); end
        tests_run++; if (bus.rW !== 5'd0) begin tests_failed++; $display("[TB] FAIL areset_rW: got %0d want 0", bus.rW); end
        tests_run++; if (bus.busW !== 32'h0) begin tests_failed++; $display("[TB] FAIL areset_busW: got %h want 0", bus.busW); end
        tests_run++; if (bus.pend !== 32'h0) begin tests_failed++; $display("[TB] FAIL areset_pend: got %h want 0", bus.pend); end
        tests_run++; if (bus.last_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL areset_last_gnt: got %b want 1", bus.last_gnt); end
        @(negedge clk); #1;
        tests_run++; if (rf[3] !== 32'h0) begin tests_failed++; $display("[TB] FAIL areset_rf3: got %h want 0", rf[3]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Randomized traffic against a transaction-level model: each requester
    // holds one pending write until accepted; the model picks the winner
    // from the arbitration rules and tracks the expected register file.
    task automatic test_random();
        int          ptr;
        int          g;
        logic        v [2];
        logic [4:0]  a [2];
        logic [31:0] d [2];
        logic        h;
        logic        exp_we;
        logic [4:0]  exp_rw;
        logic [31:0] exp_bus;
        logic [31:0] exp_pend;
        logic [31:0] ref_rf [32];
        bit          written [32];
        do_reset();
        ptr = 1; exp_we = 1'b0; exp_rw = '0; exp_bus = '0;
        v[0] = 1'b0; v[1] = 1'b0;
        for (int i = 0; i < 32; i++) begin ref_rf[i] = '0; written[i] = 1'b0; end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && $urandom_range(2) != 0) begin
                    v[i] = 1'b1;
                    a[i] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                    d[i] = $urandom;
                end
            end
            h = ($urandom_range(4) == 0);
            bus.hold = h;
            bus.req0_valid = v[0]; bus.req0_addr = a[0]; bus.req0_data = d[0];
            bus.req1_valid = v[1]; bus.req1_addr = a[1]; bus.req1_data = d[1];
            if (h)                g = -1;
            else if (v[0] && v[1]) g = 1 - ptr;
            else if (v[0])         g = 0;
            else if (v[1])         g = 1;
            else                   g = -1;
            #1;
            tests_run++; if (bus.req0_ready !== (g == 0)) begin tests_failed++; $display("[TB] FAIL rand_ready0[%0d]: got %b want %b", c, bus.req0_ready, g == 0); end
            tests_run++; if (bus.req1_ready !== (g == 1)) begin tests_failed++; $display("[TB] FAIL rand_ready1[%0d]: got %b want %b", c, bus.req1_ready, g == 1); end
            @(posedge clk); #1;
            if (g >= 0) begin
                exp_rw  = a[g];
                exp_bus = d[g];
                exp_we  = (a[g] != 5'd0);
                ptr     = g;
                if (exp_we) begin ref_rf[a[g]] = d[g]; written[a[g]] = 1'b1; end
                v[g] = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
            exp_pend = exp_we ? (32'h1 << exp_rw) : 32'h0;
            tests_run++; if (bus.wE !== exp_we) begin tests_failed++; $display("[TB] FAIL rand_wE[%0d]: got %b want %b", c, bus.wE, exp_we); end
            tests_run++; if (bus.rW !== exp_rw) begin tests_failed++; $display("[TB] FAIL rand_rW[%0d]: got %0d want %0d", c, bus.rW, exp_rw); end
            tests_run++; if (bus.busW !== exp_bus) begin tests_failed++; $display("[TB] FAIL rand_busW[%0d]: got %h want %h", c, bus.busW, exp_bus); end
            tests_run++; if (bus.pend !== exp_pend) begin tests_failed++; $display("[TB] FAIL rand_pend[%0d]: got %h want %h", c, bus.pend, exp_pend); end
            tests_run++; if (bus.last_gnt !== ptr[0]) begin tests_failed++; $display("[TB] FAIL rand_last_gnt[%0d]: got %b want %0d", c, bus.last_gnt, ptr); end
        end
        set_idle();
        @(negedge clk); #1;
        for (int i = 1; i < 32; i++) begin
            if (written[i]) begin
                tests_run++; if (rf[i] !== ref_rf[i]) begin tests_failed++; $display("[TB] FAIL rand_rf[%0d]: got %h want %h", i, rf[i], ref_rf[i]); end
            end
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_single();
        test_contention();
        test_r0();
        test_hold();
        test_same_target();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
